// File: rtl/vstore_burst_sequencer.sv
// vstore_burst_sequencer: issues one meta record per store request, then splits it into
// 4KiB/MaxBurstBeats-bounded AXI bursts with lockstep AW and txn_ctrl handshakes.
module vstore_burst_sequencer #(
    parameter int AxiAddrWidth   = 64,
    parameter int AxiDataWidth   = 128,
    parameter int MaxBurstBeats  = 256,
    parameter int MaxOutstanding = 8,
    parameter int LenWidth       = 16,
    localparam int BusBytes      = AxiDataWidth / 8,
    localparam int OffW          = $clog2(BusBytes)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]     req_nbytes_i,
    output logic                    meta_valid_o,
    input  logic                    meta_ready_i,
    output logic [LenWidth-1:0]     meta_nbytes_o,
    output logic [OffW-1:0]         meta_off_o,
    output logic                    txn_valid_o,
    input  logic                    txn_ready_i,
    output logic [12:0]             txn_nbytes_o,
    output logic [OffW-1:0]         txn_off_o,
    output logic                    txn_last_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [AxiAddrWidth-1:0] aw_addr_o,
    output logic [7:0]              aw_len_o,
    output logic [2:0]              aw_size_o,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    input  logic [1:0]              b_resp_i,
    output logic                    done_valid_o,
    input  logic                    done_ready_i,
    output logic                    done_err_o
);
    localparam int MaxBytes = MaxBurstBeats * BusBytes;
    localparam int CW       = (LenWidth + 1 > $clog2(MaxBytes) + 1) ? LenWidth + 1 : $clog2(MaxBytes) + 1;
    localparam int CntW     = $clog2(MaxOutstanding + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_META  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              r_state;
    logic [AxiAddrWidth-1:0] r_addr;
    logic [LenWidth-1:0]     r_rem;
    logic [LenWidth-1:0]     r_total;
    logic                    r_aw_sent;
    logic                    r_txn_sent;
    logic                    r_err;
    logic [CntW-1:0]         r_cnt;
    logic [OffW-1:0]         w_off;
    logic [CW-1:0]           w_rem;
    logic [CW-1:0]           w_to4k;
    logic [CW-1:0]           w_maxb;
    logic [CW-1:0]           w_nb0;
    logic [CW-1:0]           w_nb;
    logic [CW-1:0]           w_span;
    logic                    w_burst;
    logic                    w_last;
    logic                    w_aw_hs;
    logic                    w_txn_hs;
    logic                    w_unused;

    // Burst geometry is derived from the registered cursor, so it is stable while valids wait
    assign w_burst  = r_state == S_BURST;
    assign w_off    = r_addr[OffW-1:0];
    assign w_rem    = CW'(r_rem);
    assign w_to4k   = CW'(4096) - CW'(r_addr[11:0]);
    assign w_maxb   = CW'(MaxBytes) - CW'(w_off);
    assign w_nb0    = w_rem < w_to4k ? w_rem : w_to4k;
    assign w_nb     = w_maxb < w_nb0 ? w_maxb : w_nb0;
    assign w_span   = CW'(w_off) + w_nb - CW'(1);
    assign w_last   = w_nb == w_rem;
    assign w_unused = b_resp_i[0];

    assign req_ready_o   = r_state == S_IDLE;
    assign meta_valid_o  = r_state == S_META;
    assign meta_nbytes_o = r_total;
    assign meta_off_o    = w_off;
    assign aw_valid_o    = w_burst && !r_aw_sent && (r_cnt < CntW'(MaxOutstanding));
    assign txn_valid_o   = w_burst && !r_txn_sent;
    assign aw_addr_o     = w_burst ? r_addr : '0;
    assign aw_len_o      = w_burst ? 8'(w_span >> OffW) : '0;
    assign aw_size_o     = 3'(OffW);
    assign txn_nbytes_o  = w_burst ? 13'(w_nb) : '0;
    assign txn_off_o     = w_burst ? w_off : '0;
    assign txn_last_o    = w_burst && w_last;
    assign b_ready_o     = 1'b1;
    assign done_valid_o  = r_state == S_DONE;
    assign done_err_o    = r_err;
    assign w_aw_hs       = aw_valid_o && aw_ready_i;
    assign w_txn_hs      = txn_valid_o && txn_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_total    <= '0;
            r_aw_sent  <= 1'b0;
            r_txn_sent <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_aw_hs && !b_valid_i)
                r_cnt <= r_cnt + CntW'(1);
            else if (!w_aw_hs && b_valid_i && r_cnt != '0)
                r_cnt <= r_cnt - CntW'(1);
            if (b_valid_i)
                r_err <= r_err | b_resp_i[1];
            case (r_state)
                S_IDLE: if (req_valid_i) begin
                    r_addr  <= req_addr_i;
                    r_rem   <= req_nbytes_i;
                    r_total <= req_nbytes_i;
                    r_err   <= 1'b0;
                    r_state <= req_nbytes_i != '0 ? S_META : S_DONE;
                end
                S_META: if (meta_ready_i) r_state <= S_BURST;
                S_BURST: if (r_aw_sent && r_txn_sent) begin
                    r_addr     <= r_addr + AxiAddrWidth'(w_nb);
                    r_rem      <= r_rem - LenWidth'(w_nb);
                    r_aw_sent  <= 1'b0;
                    r_txn_sent <= 1'b0;
                    if (w_last) r_state <= S_DRAIN;
                end else begin
                    if (w_aw_hs) r_aw_sent <= 1'b1;
                    if (w_txn_hs) r_txn_sent <= 1'b1;
                end
                S_DRAIN: if (r_cnt == '0) r_state <= S_DONE;
                S_DONE: if (done_ready_i) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    b_without_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni) !(b_valid_i && r_cnt == '0));
endmodule
